// File: rtl/permute_pkg.sv
// Shared constants, types and index mapping for the permute1234 select interface.
package permute_pkg;

    localparam int NUM_PERMUTATIONS    = 24;
    localparam int SETS_PER_GROUP      = 4;
    localparam int PERMS_PER_SET       = 6;
    localparam int SET_WIDTH           = 2;
    localparam int PERM_IN_SET_WIDTH   = 3;
    localparam int INDEX_WIDTH         = SET_WIDTH + PERM_IN_SET_WIDTH;
    localparam int GRAPH_WIDTH_DEFAULT = 128;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_PERMUTATIONS - 1);

    typedef logic [INDEX_WIDTH-1:0] permIndex_t;

    // Field order matches idx: perm-in-set in the upper bits, set in the lower bits.
    typedef struct packed {
        logic [PERM_IN_SET_WIDTH-1:0] permInSet;
        logic [SET_WIDTH-1:0]         set;
    } permSelect_t;

    typedef enum logic {
        IDLE,
        RUN
    } genState_t;

    // Split a 0..23 permutation index into the {selectedPermutationInSet, selectedSet} pair.
    function automatic permSelect_t indexToSelect(input permIndex_t idx);
        permSelect_t sel;
        sel.set       = idx[SET_WIDTH-1:0];
        sel.permInSet = idx[INDEX_WIDTH-1:SET_WIDTH];
        return sel;
    endfunction

endpackage

// File: rtl/permutation_stream_generator_if.sv
// Graph input stream and permutation-select output stream of the generator.
interface permutation_stream_generator_if
    import permute_pkg::*;
#(
    parameter int GRAPH_WIDTH = GRAPH_WIDTH_DEFAULT
) ();

    logic [GRAPH_WIDTH-1:0]       in_graph;
    logic                         in_valid;
    logic                         in_ready;

    logic [GRAPH_WIDTH-1:0]       out_graph;
    logic [SET_WIDTH-1:0]         out_set;
    logic [PERM_IN_SET_WIDTH-1:0] out_perm_in_set;
    logic                         out_first;
    logic                         out_last;
    logic                         out_valid;
    logic                         out_ready;

    // Generator side: consumes graphs, produces select beats.
    modport master (
        input  in_graph,
        input  in_valid,
        output in_ready,
        output out_graph,
        output out_set,
        output out_perm_in_set,
        output out_first,
        output out_last,
        output out_valid,
        input  out_ready
    );

    // Environment side: graph source FIFO plus downstream permuter.
    modport slave (
        output in_graph,
        output in_valid,
        input  in_ready,
        input  out_graph,
        input  out_set,
        input  out_perm_in_set,
        input  out_first,
        input  out_last,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/permutation_index_counter.sv
// Wrapping 0..23 permutation index with enable, clear and a last-index flag.
module permutation_index_counter
    import permute_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    output permIndex_t idx,
    output logic       last
);

    assign last = (idx == LAST_INDEX);

    // Advance one permutation per enable; wrapping 23 -> 0 leaves idx ready for the next graph.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (enable) begin
            idx <= last ? '0 : idx + INDEX_WIDTH'(1);
        end
    end

endmodule

// File: rtl/permutation_stream_generator.sv
// Holds one graph and emits 24 select beats for it, with a one-entry prefetch for gapless streaming.
module permutation_stream_generator
    import permute_pkg::*;
#(
    parameter int GRAPH_WIDTH = GRAPH_WIDTH_DEFAULT,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    permutation_stream_generator_if.master bus,
    output logic [COUNT_WIDTH-1:0] graphs_done
);

    genState_t              state;
    genState_t              stateNext;
    logic [GRAPH_WIDTH-1:0] activeGraph;
    logic [GRAPH_WIDTH-1:0] prefetchGraph;
    logic                   prefetchFull;
    logic [COUNT_WIDTH-1:0] graphsDone;
    permIndex_t             idx;
    logic                   idxLast;
    permSelect_t            sel;

    logic inFire;
    logic outFire;
    logic retire;

    logic loadFromInput;
    logic loadFromPrefetch;
    logic writePrefetch;
    logic clearPrefetch;
    logic clearIndex;

    // Input is taken whenever the prefetch slot is free; in IDLE the slot is always free.
    assign bus.in_ready = !prefetchFull;
    assign inFire       = bus.in_valid && !prefetchFull;
    assign outFire      = (state == RUN) && bus.out_ready;
    assign retire       = outFire && idxLast;

    // Decide where the next active graph comes from and whether the block keeps running.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        stateNext        = state;
        loadFromInput    = 1'b0;
        loadFromPrefetch = 1'b0;
        writePrefetch    = 1'b0;
        clearPrefetch    = 1'b0;
        clearIndex       = 1'b0;
        case (state)
            IDLE: begin
                if (inFire) begin
                    loadFromInput = 1'b1;
                    clearIndex    = 1'b1;
                    stateNext     = RUN;
                end
            end
            RUN: begin
                if (retire) begin
                    // idx wraps to 0 on this same beat, so a successor starts at permutation 0.
                    if (prefetchFull) begin
                        loadFromPrefetch = 1'b1;
                        clearPrefetch    = 1'b1;
                    end else if (inFire) begin
                        loadFromInput = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (inFire) begin
                    writePrefetch = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Graph payload registers; their contents only matter while the matching valid/full flag is set.
    always_ff @(posedge clk) begin
        // NOTE: wide data registers are left unreset; state and flags alone define validity.
        if (loadFromInput) begin
            activeGraph <= bus.in_graph;
        end else if (loadFromPrefetch) begin
            activeGraph <= prefetchGraph;
        end
        if (writePrefetch) begin
            prefetchGraph <= bus.in_graph;
        end
    end

    // Prefetch occupancy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prefetchFull <= 1'b0;
        end else if (writePrefetch) begin
            prefetchFull <= 1'b1;
        end else if (clearPrefetch) begin
            prefetchFull <= 1'b0;
        end
    end

    // Count graphs whose last beat was accepted; wraps naturally at the counter width.
    always_ff @(posedge clk) begin
        if (rst) begin
            graphsDone <= '0;
        end else if (retire) begin
            graphsDone <= graphsDone + COUNT_WIDTH'(1);
        end
    end

    permutation_index_counter u_index (
        .clk    (clk),
        .rst    (rst),
        .enable (outFire),
        .clear  (clearIndex),
        .idx    (idx),
        .last   (idxLast)
    );

    assign sel                 = indexToSelect(idx);
    assign bus.out_valid       = (state == RUN);
    assign bus.out_graph       = activeGraph;
    assign bus.out_set         = sel.set;
    assign bus.out_perm_in_set = sel.permInSet;
    assign bus.out_first       = (idx == '0);
    assign bus.out_last        = idxLast;
    assign graphs_done         = graphsDone;

endmodule
